// File: rtl/rd_ptr_handlr.sv
// Read-side pointer/empty handler for an async FIFO with a first-word-fall-through output register.
// Optional build macro RD_ALMOST_EMPTY_EN adds AE_LEVEL and the registered rd_level / rd_aempty.
module rd_ptr_handlr #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 8
`ifdef RD_ALMOST_EMPTY_EN
  , parameter int unsigned AE_LEVEL = 2
`endif
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  input  logic [DATA_SIZE-1:0] rdata_mem,
  input  logic                 rd_ready,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 rd_valid,
`ifdef RD_ALMOST_EMPTY_EN
  output logic [ADDR_SIZE:0]   rd_level,
  output logic                 rd_aempty,
`endif
  output logic [DATA_SIZE-1:0] rd_data
);

  typedef enum logic {StEmpty, StValid} out_state_e;

  out_state_e         state;
  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbin_next;
  logic [ADDR_SIZE:0] rgray_next;
  logic               fetch;

  assign rd_valid   = (state == StValid);
  // A word leaves the RAM whenever the output register is free or being drained this cycle.
  assign fetch      = ~rempty & (~rd_valid | rd_ready);
  assign rbin_next  = rbin + {{ADDR_SIZE{1'b0}}, fetch};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin[ADDR_SIZE-1:0];

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      rempty <= (rgray_next == rq2_wptr);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state   <= StEmpty;
      rd_data <= '0;
    end else begin
      unique case (state)
        StEmpty: begin
          if (fetch) begin
            rd_data <= rdata_mem;
            state   <= StValid;
          end
        end
        StValid: begin
          if (rd_ready) begin
            if (fetch) begin
              rd_data <= rdata_mem;
            end else begin
              state <= StEmpty;
            end
          end
        end
      endcase
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  localparam logic [ADDR_SIZE:0] AeLevel = AE_LEVEL[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] rq2_wbin;
  logic [ADDR_SIZE:0] level_next;

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    rq2_wbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      rq2_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign level_next = rq2_wbin - rbin_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_level  <= '0;
      rd_aempty <= 1'b1;
    end else begin
      rd_level  <= level_next;
      rd_aempty <= (level_next <= AeLevel);
    end
  end
`endif

endmodule

// File: tb/tb_rd_ptr_handlr.sv
// Self-checking bench for rd_ptr_handlr: directed vector table, hand-written corner sequences,
// and randomized traffic against a word-count reference model.
`timescale 1ns/1ps
module tb_rd_ptr_handlr;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic [AW:0]   rq2_wptr = '0;
  logic [DW-1:0] rdata_mem;
  logic          rd_ready = 1'b0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
`ifdef RD_ALMOST_EMPTY_EN
  logic [AW:0]   rd_level;
  logic          rd_aempty;
`endif

  logic [DW-1:0] mem [16];
  assign rdata_mem = mem[raddr];

  always #5 rclk = ~rclk;

  rd_ptr_handlr #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .rd_ready  (rd_ready),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rd_valid  (rd_valid),
`ifdef RD_ALMOST_EMPTY_EN
    .rd_level  (rd_level),
    .rd_aempty (rd_aempty),
`endif
    .rd_data   (rd_data)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [AW:0]   wptr;
    logic          rdy;
    logic          empty;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [AW:0]   ptr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [AW:0] gray(int unsigned n);
    logic [AW:0] b;
    b = n[AW:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) mem[i] = DW'(8'hA0 + i);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n   = 1'b0;
    rq2_wptr = '0;
    rd_ready = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // Reference model state: counts of words written and fetched out of RAM.
  int unsigned   m_w, m_f;
  logic          m_valid, m_empty;
  logic [DW-1:0] m_word;
  logic [DW-1:0] words[$];

  initial begin
    init_mem();

    // Reset is asynchronous: outputs must clear before any clock edge.
    #2;
    rq2_wptr = 5'b00011;
    rrst_n   = 1'b0;
    #1;
    check("rst.rempty", 32'(rempty), 32'd1);
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.rptr", 32'(rptr), 32'd0);
    check("rst.raddr", 32'(raddr), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    rq2_wptr = '0;
    @(negedge rclk);
    rrst_n = 1'b1;

    // Single word, then 10-cycle stall with 3 words, then drain.
    tbl.push_back('{5'b00001, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 5'b00000});
    tbl.push_back('{5'b00001, 1'b0, 1'b1, 1'b1, 8'hA0, 4'd1, 5'b00001});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{5'b00010, 1'b0, 1'b0, 1'b1, 8'hA0, 4'd1, 5'b00001});
    tbl.push_back('{5'b00010, 1'b1, 1'b0, 1'b1, 8'hA1, 4'd2, 5'b00011});
    tbl.push_back('{5'b00010, 1'b1, 1'b1, 1'b1, 8'hA2, 4'd3, 5'b00010});
    tbl.push_back('{5'b00010, 1'b1, 1'b1, 1'b0, 8'hA2, 4'd3, 5'b00010});
    foreach (tbl[i]) begin
      @(negedge rclk);
      rq2_wptr = tbl[i].wptr;
      rd_ready = tbl[i].rdy;
      @(posedge rclk);
      #1;
      check($sformatf("vec%0d.rempty", i), 32'(rempty), 32'(tbl[i].empty));
      check($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].valid));
      check($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].data));
      check($sformatf("vec%0d.raddr", i), 32'(raddr), 32'(tbl[i].addr));
      check($sformatf("vec%0d.rptr", i), 32'(rptr), 32'(tbl[i].ptr));
    end

    // Full 16-word stream, then a second lap that wraps the pointer.
    do_reset();
    @(negedge rclk);
    rq2_wptr = 5'b11000;
    rd_ready = 1'b1;
    @(posedge rclk); #1;
    check("full.rempty_up", 32'(rempty), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(posedge rclk); #1;
      check($sformatf("full.beat%0d.valid", k), 32'(rd_valid), 32'd1);
      check($sformatf("full.beat%0d.data", k), 32'(rd_data), 32'(8'hA0 + k));
    end
    check("full.rptr_end", 32'(rptr), 32'b11000);
    check("full.rempty_end", 32'(rempty), 32'd1);
    @(negedge rclk);
    rq2_wptr = 5'b00000;
    @(posedge rclk); #1;
    check("wrap.rempty_up", 32'(rempty), 32'd0);
    check("wrap.gap_valid", 32'(rd_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(posedge rclk); #1;
      check($sformatf("wrap.beat%0d.valid", k), 32'(rd_valid), 32'd1);
      check($sformatf("wrap.beat%0d.data", k), 32'(rd_data), 32'(8'hA0 + k));
      check($sformatf("wrap.beat%0d.rempty", k), 32'(rempty), (k == 15) ? 32'd1 : 32'd0);
    end
    check("wrap.rptr_end", 32'(rptr), 32'd0);

    // Reset pulse between edges while a word is held.
    do_reset();
    @(negedge rclk);
    rq2_wptr = 5'b00110;
    rd_ready = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    check("mrst.pre_valid", 32'(rd_valid), 32'd1);
    #1;
    rrst_n   = 1'b0;
    rq2_wptr = '0;
    #1;
    check("mrst.rd_valid", 32'(rd_valid), 32'd0);
    check("mrst.rempty", 32'(rempty), 32'd1);
    check("mrst.rptr", 32'(rptr), 32'd0);
    check("mrst.raddr", 32'(raddr), 32'd0);
    #2;
    rrst_n   = 1'b1;
    rq2_wptr = 5'b00001;
    @(posedge rclk); #1;
    check("mrst.rempty_up", 32'(rempty), 32'd0);
    @(posedge rclk); #1;
    check("mrst.refetch_valid", 32'(rd_valid), 32'd1);
    check("mrst.refetch_data", 32'(rd_data), 32'hA0);

`ifdef RD_ALMOST_EMPTY_EN
    // 4 words, streaming: level counts down through the almost-empty threshold.
    do_reset();
    @(negedge rclk);
    rq2_wptr = 5'b00110;
    rd_ready = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      @(posedge rclk); #1;
      check($sformatf("ae.level%0d", k), 32'(rd_level), 32'(k));
      check($sformatf("ae.aempty%0d", k), 32'(rd_aempty), (k <= 2) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized traffic against the word-count model.
    do_reset();
    m_w = 0; m_f = 0; m_valid = 1'b0; m_empty = 1'b1; m_word = '0;
    words.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge rclk);
      rd_ready = ($urandom_range(0, 3) != 0);
      // Writer stops after cycle 500 so the tail drains; RAM never holds more than 16 words.
      if (cyc < 500 && $urandom_range(0, 2) != 0 && (m_w - (m_f - 32'(m_valid))) < 16) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        mem[m_w % 16] = w;
        words.push_back(w);
        m_w++;
        rq2_wptr = gray(m_w);
      end
      @(posedge rclk);
      if (!m_empty && (!m_valid || rd_ready)) begin
        m_word  = words[m_f];
        m_valid = 1'b1;
        m_f++;
      end else if (rd_ready) begin
        m_valid = 1'b0;
      end
      m_empty = (m_w == m_f);
      #1;
      check("rnd.rd_valid", 32'(rd_valid), 32'(m_valid));
      if (m_valid) check("rnd.rd_data", 32'(rd_data), 32'(m_word));
      check("rnd.rempty", 32'(rempty), 32'(m_empty));
      check("rnd.raddr", 32'(raddr), m_f % 16);
      check("rnd.rptr", 32'(rptr), 32'(gray(m_f)));
`ifdef RD_ALMOST_EMPTY_EN
      check("rnd.rd_level", 32'(rd_level), m_w - m_f);
      check("rnd.rd_aempty", 32'(rd_aempty), ((m_w - m_f) <= 2) ? 32'd1 : 32'd0);
`endif
    end
    @(negedge rclk);
    rd_ready = 1'b1;
    repeat (20) @(posedge rclk);
    #1;
    check("drain.rd_valid", 32'(rd_valid), 32'd0);
    check("drain.rempty", 32'(rempty), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
